step_pulse_gen: RTL and testbench

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pulse_gen_pkg.sv | 19 +
 rtl/step_pulse_gen_debounce_ch.sv | 93 +++++++++
 rtl/step_pulse_gen.sv | 58 +++++
 tb/tb_step_pulse_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/step_pulse_gen_pkg.sv
// Shared definitions for the button step-pulse generator: debounce FSM encoding
// and the default debounce window length.
package step_pulse_gen_pkg;

  localparam int DEBOUNCE_DEFAULT = 50000;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    RELEASED     = ST_RELEASED,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } db_state_t;

endpackage

// File: rtl/step_pulse_gen_debounce_ch.sv
// One button channel: 2-flop synchronizer, saturating run counter and debounce FSM.
// press is combinational and marks the edge on which the FSM enters PRESSED.
module debounce_ch
  import step_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic lvl
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            sync1, sync2;
  db_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    cnt_inc   = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
    case (state)
      RELEASED: begin
        if (sync2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press     = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (sync2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign lvl = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/step_pulse_gen.sv
// Two debounced buttons turned into single-cycle up/down step requests.
// step/dir are registered one cycle after a press event; coincident presses cancel.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  output logic step,
  output logic dir,
  output logic up_lvl,
  output logic dn_lvl
);

  logic up_press, dn_press;

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .press (up_press),
    .lvl   (up_lvl)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_dn),
    .press (dn_press),
    .lvl   (dn_lvl)
  );

  // dir only moves on an unambiguous press, so it holds between steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step <= 1'b0;
      dir  <= 1'b1;
    end else begin
      step <= up_press ^ dn_press;
      if (up_press && !dn_press) begin
        dir <= 1'b1;
      end else if (dn_press && !up_press) begin
        dir <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen with DEBOUNCE_CYCLES = 4: directed scenarios
// followed by random button activity, checked against a sample-history reference model.
module tb_step_pulse_gen;

  localparam int D = 4;

  typedef struct packed {
    logic step;
    logic dir;
    logic up;
    logic dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic step, dir, up_lvl, dn_lvl;

  int total = 0;
  int bad   = 0;
  int steps = 0;
  int step_edge = 0;
  int edge_n = 0;

  exp_t expq[$];
  logic hu[$];
  logic hd[$];
  logic m_up, m_dn, m_dir;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .step   (step),
    .dir    (dir),
    .up_lvl (up_lvl),
    .dn_lvl (dn_lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // A channel's level flips once the last D synchronized samples (raw input two
  // edges earlier) all disagree with it; samples before reset count as 0.
  function automatic logic settled(input logic h[$], input logic lvl);
    int n = h.size();
    for (int j = 0; j < D; j++) begin
      int idx = n - 3 - j;
      logic v = (idx >= 0) ? h[idx] : 1'b0;
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    hu.delete();
    hd.delete();
    m_up  = 1'b0;
    m_dn  = 1'b0;
    m_dir = 1'b1;
  endtask

  task automatic model_edge(input logic u, input logic d);
    logic pu = 1'b0;
    logic pd = 1'b0;
    exp_t e;
    hu.push_back(u);
    hd.push_back(d);
    if (settled(hu, m_up)) begin
      m_up = !m_up;
      pu   = m_up;
    end
    if (settled(hd, m_dn)) begin
      m_dn = !m_dn;
      pd   = m_dn;
    end
    while (hu.size() > D + 3) void'(hu.pop_front());
    while (hd.size() > D + 3) void'(hd.pop_front());
    if (pu && !pd) m_dir = 1'b1;
    else if (pd && !pu) m_dir = 1'b0;
    e.step = pu ^ pd;
    e.dir  = m_dir;
    e.up   = m_up;
    e.dn   = m_dn;
    expq.push_back(e);
  endtask

  // Inputs are applied just after an edge and stay stable across the next one.
  task automatic cyc(input logic u, input logic d);
    btn_up = u;
    btn_dn = d;
    @(posedge clk);
    #1;
    edge_n++;
    model_edge(u, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 1);
    chk("rst_up_lvl", up_lvl, 0);
    chk("rst_dn_lvl", dn_lvl, 0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    edge_n = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (step) begin
        steps++;
        step_edge = edge_n;
      end
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("step", step, e.step);
        chk("dir", dir, e.dir);
        chk("up_lvl", up_lvl, e.up);
        chk("dn_lvl", dn_lvl, e.dn);
      end
    end
  end

  initial begin
    logic u, d;
    model_reset();
    do_reset();

    // held up press: single step after edge D+2, no repeat
    steps = 0;
    step_edge = 0;
    repeat (20) cyc(1'b1, 1'b0);
    @(negedge clk);
    chk("hold_up_steps", steps, 1);
    chk("hold_up_latency", step_edge, D + 2);
    repeat (10) cyc(1'b0, 1'b0);

    // short down glitch then a real hold
    steps = 0;
    repeat (3) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    repeat (12) cyc(1'b0, 1'b1);
    @(negedge clk);
    chk("dn_glitch_steps", steps, 1);
    chk("dn_dir", dir, 0);
    repeat (10) cyc(1'b0, 1'b0);

    // simultaneous press is suppressed
    steps = 0;
    repeat (12) cyc(1'b1, 1'b1);
    @(negedge clk);
    chk("simul_steps", steps, 0);
    chk("simul_up_lvl", up_lvl, 1);
    chk("simul_dn_lvl", dn_lvl, 1);
    repeat (10) cyc(1'b0, 1'b0);

    // up press while down already pressed
    steps = 0;
    repeat (10) cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b1, 1'b1);
    @(negedge clk);
    chk("overlap_steps", steps, 2);
    chk("overlap_dir", dir, 1);
    repeat (10) cyc(1'b0, 1'b0);

    // release with bounce
    repeat (10) cyc(1'b1, 1'b0);
    steps = 0;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    @(negedge clk);
    chk("bounce_steps", steps, 0);

    // reset mid-press with button still held
    repeat (4) cyc(1'b1, 1'b0);
    do_reset();
    steps = 0;
    step_edge = 0;
    repeat (12) cyc(1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_steps", steps, 1);
    chk("post_rst_latency", step_edge, D + 2);
    repeat (10) cyc(1'b0, 1'b0);

    // random activity
    u = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) u = !u;
      if ($urandom_range(0, 5) == 0) d = !d;
      cyc(u, d);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
